countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/timer_pkg.sv | 7 +
 rtl/hex_to_seven_seg.sv | 29 ++
 rtl/countdown_timer.sv | 85 ++++++++
 tb/tb_countdown_timer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, count width and segment constants for countdown_timer.
package timer_pkg;
    localparam int CW = 8;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
endpackage

// File: rtl/hex_to_seven_seg.sv
// hex_to_seven_seg: 4-bit value to active-low segments, bit 0 = a ... bit 6 = g.
module hex_to_seven_seg
    import timer_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    always_comb begin
        case (hex)
            4'h0: seg = SEG_ZERO;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'ha: seg = 7'b0001000;
            4'hb: seg = 7'b0000011;
            4'hc: seg = 7'b1000110;
            4'hd: seg = 7'b0100001;
            4'he: seg = 7'b0000110;
            4'hf: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable 8-bit down counter with pause, divided step rate and hex display.
// AUTO_RELOAD_EN: restart from the last loaded value on expiry instead of halting.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
)(
    input  logic          clk,
    input  logic          clear,
    input  logic          enable,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          rate_sel,
    output logic [CW-1:0] count,
    output logic          done,
    output logic          expired,
    output logic [6:0]    HEX1,
    output logic [6:0]    HEX0
);
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

    state_t state, state_nxt;
    logic [DW-1:0] div;
    logic [CW-1:0] rl;
    logic tick, last, step;

    assign step = state == RUN && enable;
    assign tick = !rate_sel || div == DIV_MAX;
    assign last = tick && count == CW'(1);

`ifdef AUTO_RELOAD_EN
    logic [CW-1:0] reload;
    always_ff @(posedge clk) begin
        if (clear)
            reload <= '0;
        else if (load)
            reload <= load_value;
    end
    assign rl = reload;
`else
    assign rl = '0;
`endif

    always_ff @(posedge clk) begin
        if (clear)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A zero reload value means the expiry step lands on 0, so halt in EXPIRED.
    always_comb begin
        state_nxt = load ? IDLE :
                    state == IDLE ? (enable && count != '0 ? RUN : IDLE) :
                    state == RUN ? (!enable ? IDLE : last && rl == '0 ? EXPIRED : RUN) :
                    EXPIRED;
    end

    always_comb begin
        expired = state == EXPIRED;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
            div <= '0;
            done <= 1'b0;
        end else if (load) begin
            count <= load_value;
            div <= '0;
            done <= 1'b0;
        end else begin
            done <= step && last;
            if (step) begin
                div <= div == DIV_MAX ? '0 : div + 1'b1;
                if (tick)
                    count <= last ? rl : count - 1'b1;
            end
        end
    end

    hex_to_seven_seg u_hex1 (.hex(count[7:4]), .seg(HEX1));
    hex_to_seven_seg u_hex0 (.hex(count[3:0]), .seg(HEX0));
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed stimulus with a queue scoreboard checked by a negedge monitor.
module tb_countdown_timer;
    logic clk = 1'b0;
    logic clear, enable, load, rate_sel;
    logic [7:0] load_value, count;
    logic done, expired;
    logic [6:0] HEX1, HEX0;

    typedef struct {
        logic [7:0] c;
        logic d;
        logic x;
        string nm;
    } exp_t;

    exp_t sb[$];
    exp_t it;
    int total = 0;
    int passed = 0;
    logic [7:0] hv [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hab, 8'hcd, 8'hef};

    countdown_timer #(.TICK_DIV(4)) dut (
        .clk(clk), .clear(clear), .enable(enable), .load(load),
        .load_value(load_value), .rate_sel(rate_sel), .count(count),
        .done(done), .expired(expired), .HEX1(HEX1), .HEX0(HEX0)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'ha: return 7'b0001000;
            4'hb: return 7'b0000011;
            4'hc: return 7'b1000110;
            4'hd: return 7'b0100001;
            4'he: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic step(input logic cl, ld, en, rs, input logic [7:0] lv, ec,
                        input logic ed, ex, input string nm);
        clear = cl;
        load = ld;
        enable = en;
        rate_sel = rs;
        load_value = lv;
        @(posedge clk);
        #1;
        sb.push_back('{ec, ed, ex, nm});
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            it = sb.pop_front();
            total++;
            if ({count, done, expired, HEX1, HEX0} !== {it.c, it.d, it.x, seg(it.c[7:4]), seg(it.c[3:0])})
                $display("FAIL %s: got count=%h done=%b expired=%b HEX1=%b HEX0=%b, want count=%h done=%b expired=%b HEX1=%b HEX0=%b",
                         it.nm, count, done, expired, HEX1, HEX0,
                         it.c, it.d, it.x, seg(it.c[7:4]), seg(it.c[3:0]));
            else
                passed++;
        end
    end

    initial begin
        {clear, load, enable, rate_sel} = '0;
        load_value = '0;
        step(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, "reset");
        // fast countdown to expiry
        step(0, 1, 1, 0, 8'h03, 8'h03, 0, 0, "load3");
        step(0, 0, 1, 0, 8'h00, 8'h03, 0, 0, "idle_to_run");
        step(0, 0, 1, 0, 8'h00, 8'h02, 0, 0, "dec2");
        step(0, 0, 1, 0, 8'h00, 8'h01, 0, 0, "dec1");
        step(0, 0, 1, 0, 8'h00, 8'h00, 1, 1, "expire");
        step(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, "expired_hold");
        step(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, "expired_en0");
        // divided rate with a pause
        step(0, 1, 1, 1, 8'h02, 8'h02, 0, 0, "load2_slow");
        step(0, 0, 1, 1, 8'h00, 8'h02, 0, 0, "slow_run");
        step(0, 0, 1, 1, 8'h00, 8'h02, 0, 0, "slow_d1");
        step(0, 0, 1, 1, 8'h00, 8'h02, 0, 0, "slow_d2");
        step(0, 0, 1, 1, 8'h00, 8'h02, 0, 0, "slow_d3");
        step(0, 0, 1, 1, 8'h00, 8'h01, 0, 0, "slow_tick");
        step(0, 0, 1, 1, 8'h00, 8'h01, 0, 0, "slow2_d1");
        step(0, 0, 1, 1, 8'h00, 8'h01, 0, 0, "slow2_d2");
        step(0, 0, 0, 1, 8'h00, 8'h01, 0, 0, "pause1");
        step(0, 0, 0, 1, 8'h00, 8'h01, 0, 0, "pause2");
        step(0, 0, 0, 1, 8'h00, 8'h01, 0, 0, "pause3");
        step(0, 0, 1, 1, 8'h00, 8'h01, 0, 0, "resume");
        step(0, 0, 1, 1, 8'h00, 8'h01, 0, 0, "resume_d3");
        step(0, 0, 1, 1, 8'h00, 8'h00, 1, 1, "slow_expire");
        // load on the tick cycle wins over the decrement
        step(0, 1, 1, 1, 8'h09, 8'h09, 0, 0, "load9");
        step(0, 0, 1, 1, 8'h00, 8'h09, 0, 0, "run9");
        step(0, 0, 1, 1, 8'h00, 8'h09, 0, 0, "run9_d1");
        step(0, 0, 1, 1, 8'h00, 8'h09, 0, 0, "run9_d2");
        step(0, 0, 1, 1, 8'h00, 8'h09, 0, 0, "run9_d3");
        step(0, 1, 1, 1, 8'h55, 8'h55, 0, 0, "load_beats_tick");
        step(0, 0, 1, 0, 8'h00, 8'h55, 0, 0, "load_to_idle");
        // rate_sel switched mid-run keeps the divider phase
        step(0, 0, 1, 1, 8'h00, 8'h55, 0, 0, "rs1_d1");
        step(0, 0, 1, 0, 8'h00, 8'h54, 0, 0, "rs0_tick");
        step(0, 0, 1, 1, 8'h00, 8'h54, 0, 0, "rs1_d3");
        step(0, 0, 1, 1, 8'h00, 8'h53, 0, 0, "rs1_tick");
        // zero load never runs
        step(0, 1, 1, 0, 8'h00, 8'h00, 0, 0, "load0");
        step(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, "zero_idle1");
        step(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, "zero_idle2");
        // clear beats load mid-run
        step(0, 1, 1, 0, 8'h20, 8'h20, 0, 0, "load20");
        step(0, 0, 1, 0, 8'h00, 8'h20, 0, 0, "run20");
        step(0, 0, 1, 0, 8'h00, 8'h1f, 0, 0, "dec1f");
        step(1, 1, 1, 0, 8'h77, 8'h00, 0, 0, "clear_over_load");
        step(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, "after_clear");
        foreach (hv[i])
            step(0, 1, 0, 0, hv[i], hv[i], 0, 0, "hex_glyphs");
`ifdef AUTO_RELOAD_EN
        step(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, "rl_clear");
        step(0, 1, 1, 0, 8'h02, 8'h02, 0, 0, "rl_load");
        step(0, 0, 1, 0, 8'h00, 8'h02, 0, 0, "rl_run");
        step(0, 0, 1, 0, 8'h00, 8'h01, 0, 0, "rl_dec1");
        step(0, 0, 1, 0, 8'h00, 8'h02, 1, 0, "rl_wrap");
        step(0, 0, 1, 0, 8'h00, 8'h01, 0, 0, "rl_dec1b");
        step(0, 0, 1, 0, 8'h00, 8'h02, 1, 0, "rl_wrap2");
`endif
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        if (sb.size() > 0) begin
            total++;
            $display("FAIL drain: %0d expected responses left unchecked, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
